// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      REFILL = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int DEF_BUS_WIDTH  = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_LINE_WORDS = 16;
   localparam int DEF_WAYS       = 2;
   localparam int DEF_SETS       = 32;

   function automatic int calc_off_w(input int line_words, input int data_width);
      return $clog2(line_words * data_width / 8);
   endfunction

   function automatic int calc_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int calc_tag_w(input int bus_width, input int off_w, input int idx_w);
      return bus_width - off_w - idx_w;
   endfunction

   localparam int DEF_OFF_W = calc_off_w(DEF_LINE_WORDS, DEF_DATA_WIDTH);
   localparam int DEF_IDX_W = calc_idx_w(DEF_SETS);
   localparam int DEF_TAG_W = calc_tag_w(DEF_BUS_WIDTH, DEF_OFF_W, DEF_IDX_W);

   // Extracts a tag, index or offset field from a byte address.
   function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
      return (a >> lsb) & ((64'd1 << width) - 64'd1);
   endfunction

endpackage

// File: rtl/icache_tag_way.sv
// One way of tag storage: valid bits plus tags, compared at the registered request index.
module icache_tag_way
   import icache_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W,
   parameter int TAG_W = DEF_TAG_W,
   parameter int SETS  = DEF_SETS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_we,
   input  logic             i_clr,
   output logic             o_hit,
   output logic             o_valid
);

   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag [SETS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (i_clr) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_idx] <= i_tag;
      end
   end

   assign o_valid = r_valid[i_idx];
   assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with round-robin refill.
//   state  | meaning
//   IDLE   | ready for a fetch; applies any pending invalidate first
//   LOOKUP | tag compare across all ways at the latched index
//   REFILL | fetch the whole line word by word into the victim way
//   RESP   | hold rdata/rdata_valid until the consumer accepts
module icache_nway
   import icache_pkg::*;
#(
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int WAYS       = DEF_WAYS,
   parameter int SETS       = DEF_SETS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [BUS_WIDTH-1:0]  addr,
   output logic                  req_ready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_valid,
   input  logic                  rdata_ready,
   input  logic                  invalidate,
   output logic                  mem_ce,
   output logic [BUS_WIDTH-1:0]  mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rdata_valid,
   output logic                  hit_pulse,
   output logic                  miss_pulse
);

   localparam int OFF_W  = calc_off_w(LINE_WORDS, DATA_WIDTH);
   localparam int IDX_W  = calc_idx_w(SETS);
   localparam int TAG_W  = calc_tag_w(BUS_WIDTH, OFF_W, IDX_W);
   localparam int WOFF_W = $clog2(LINE_WORDS);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   state_t                r_state, w_state_nxt;
   logic [BUS_WIDTH-1:0]  r_req_addr;
   logic [WAY_W-1:0]      r_victim;
   logic [WOFF_W-1:0]     r_cnt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rdata_valid;
   logic                  r_mem_ce;
   logic [BUS_WIDTH-1:0]  r_mem_addr;
   logic                  r_hit_pulse;
   logic                  r_miss_pulse;
   logic                  r_inv_pend;
   logic [WAY_W-1:0]      r_rr   [SETS];
   logic [DATA_WIDTH-1:0] r_data [WAYS][SETS][LINE_WORDS];

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [WOFF_W-1:0] w_woff;
   logic [WAYS-1:0]   w_hit, w_valid, w_tag_we;
   logic [WAY_W-1:0]  w_hit_way, w_victim, w_rr_next;
   logic              w_accept, w_clr, w_beat, w_last;

   assign w_tag  = TAG_W'(addr_field(64'(r_req_addr), OFF_W + IDX_W, TAG_W));
   assign w_idx  = IDX_W'(addr_field(64'(r_req_addr), OFF_W, IDX_W));
   assign w_woff = WOFF_W'(addr_field(64'(r_req_addr), 2, WOFF_W));

   // A pending invalidate steals the first IDLE cycle, so nothing is accepted then.
   assign req_ready = (r_state == IDLE) && !invalidate && !r_inv_pend;
   assign w_accept  = ce && req_ready;
   assign w_clr     = (r_state == IDLE) && (invalidate || r_inv_pend);
   assign w_beat    = (r_state == REFILL) && r_mem_ce && mem_rdata_valid;
   assign w_last    = (r_cnt == {WOFF_W{1'b1}});
   assign w_rr_next = (r_victim == WAY_W'(WAYS - 1)) ? '0 : r_victim + 1'b1;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign w_tag_we[g] = w_beat && w_last && (r_victim == WAY_W'(g));
      icache_tag_way #(.IDX_W(IDX_W), .TAG_W(TAG_W), .SETS(SETS)) u_tag (
         .clk     (clk),
         .reset   (reset),
         .i_idx   (w_idx),
         .i_tag   (w_tag),
         .i_we    (w_tag_we[g]),
         .i_clr   (w_clr),
         .o_hit   (w_hit[g]),
         .o_valid (w_valid[g])
      );
   end

   // Descending scan so the lowest-index candidate is the one that sticks.
   always_comb begin
      w_hit_way = '0;
      w_victim  = r_rr[w_idx];
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (w_hit[i]) w_hit_way = WAY_W'(i);
         if (!w_valid[i]) w_victim = WAY_W'(i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = LOOKUP;
         LOOKUP:  w_state_nxt = (|w_hit) ? RESP : REFILL;
         REFILL:  if (w_beat && w_last) w_state_nxt = RESP;
         RESP:    if (rdata_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_addr    <= '0;
         r_victim      <= '0;
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_mem_ce      <= 1'b0;
         r_mem_addr    <= '0;
         r_hit_pulse   <= 1'b0;
         r_miss_pulse  <= 1'b0;
         r_inv_pend    <= 1'b0;
         for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      end else begin
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
         if (r_state == IDLE)  r_inv_pend <= 1'b0;
         else if (invalidate)  r_inv_pend <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_accept) r_req_addr <= addr;
            end
            LOOKUP: begin
               if (|w_hit) begin
                  r_rdata       <= r_data[w_hit_way][w_idx][w_woff];
                  r_rdata_valid <= 1'b1;
                  r_hit_pulse   <= 1'b1;
               end else begin
                  r_miss_pulse <= 1'b1;
                  r_victim     <= w_victim;
                  r_cnt        <= '0;
                  r_mem_ce     <= 1'b1;
                  r_mem_addr   <= {w_tag, w_idx, {WOFF_W{1'b0}}, 2'b00};
               end
            end
            REFILL: begin
               if (w_beat) begin
                  r_mem_ce <= 1'b0;
                  r_cnt    <= r_cnt + 1'b1;
                  if (r_cnt == w_woff) r_rdata <= mem_rdata;
                  if (w_last) begin
                     r_rdata_valid <= 1'b1;
                     r_rr[w_idx]   <= w_rr_next;
                  end
               end else if (!r_mem_ce) begin
                  r_mem_ce   <= 1'b1;
                  r_mem_addr <= {w_tag, w_idx, r_cnt, 2'b00};
               end
            end
            RESP: begin
               if (rdata_ready) r_rdata_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat) r_data[r_victim][w_idx][r_cnt] <= mem_rdata;
   end

   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign mem_ce      = r_mem_ce;
   assign mem_addr    = r_mem_addr;
   assign hit_pulse   = r_hit_pulse;
   assign miss_pulse  = r_miss_pulse;

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway with a small word-by-word memory responder.
module tb_icache_nway;

   logic        clk = 1'b0;
   logic        reset, ce, rdata_ready, invalidate, mem_rdata_valid;
   logic [31:0] addr, mem_rdata;
   logic        req_ready, rdata_valid, mem_ce, hit_pulse, miss_pulse;
   logic [31:0] rdata, mem_addr;

   int n_tests = 0;
   int n_fail  = 0;
   int hit_cnt = 0;
   int miss_cnt = 0;
   int rlat = 0;
   bit mem_ce_seen = 1'b0;
   logic [31:0] beat_q [$];

   always #5 clk = ~clk;

   icache_nway dut (
      .clk             (clk),
      .reset           (reset),
      .ce              (ce),
      .addr            (addr),
      .req_ready       (req_ready),
      .rdata           (rdata),
      .rdata_valid     (rdata_valid),
      .rdata_ready     (rdata_ready),
      .invalidate      (invalidate),
      .mem_ce          (mem_ce),
      .mem_addr        (mem_addr),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid),
      .hit_pulse       (hit_pulse),
      .miss_pulse      (miss_pulse)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory answers each request one cycle after it appears, for one cycle.
   always @(negedge clk) begin
      if (hit_pulse)  hit_cnt++;
      if (miss_pulse) miss_cnt++;
      if (mem_ce)     mem_ce_seen = 1'b1;
      if (!reset) begin
         mem_rdata_valid = 1'b0;
         rlat = 0;
      end else if (mem_rdata_valid) begin
         mem_rdata_valid = 1'b0;
      end else if (mem_ce) begin
         if (rlat >= 1) begin
            mem_rdata       = mem_word(mem_addr);
            mem_rdata_valid = 1'b1;
            beat_q.push_back(mem_addr);
            rlat = 0;
         end else begin
            rlat++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic [31:0] a);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      ce   = 1'b1;
      addr = a;
      @(negedge clk);
      ce = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!rdata_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      if (!rdata_valid) check("resp_timeout", {31'b0, rdata_valid}, 32'd1);
   endtask

   task automatic accept_resp();
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
      start_req(a);
      wait_resp(lat);
      d = rdata;
      accept_resp();
   endtask

   task automatic check_line(input string tag, input logic [31:0] base);
      check({tag, "_beats"}, beat_q.size(), 32'd16);
      for (int i = 0; i < 16 && i < beat_q.size(); i++)
         check({tag, "_beat_addr"}, beat_q[i], base + 32'(4 * i));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, "_rdata_valid"}, {31'b0, rdata_valid}, 32'd0);
      check({tag, "_rdata"}, rdata, 32'd0);
      check({tag, "_mem_ce"}, {31'b0, mem_ce}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_hit_pulse"}, {31'b0, hit_pulse}, 32'd0);
      check({tag, "_miss_pulse"}, {31'b0, miss_pulse}, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int lat, m0, h0, n;

      reset = 1'b0; ce = 1'b0; addr = '0; rdata_ready = 1'b0; invalidate = 1'b0;
      mem_rdata = '0; mem_rdata_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      // Cold miss at 0x104: full line from 0x100, requested word returned.
      beat_q.delete();
      fetch(32'h0000_0104, d, lat);
      check("cold_rdata", d, 32'hC0DE_0104);
      check_line("cold", 32'h0000_0100);
      check("cold_miss_cnt", 32'(miss_cnt), 32'd1);
      check("cold_hit_cnt", 32'(hit_cnt), 32'd0);

      // Hit in the same line: two-cycle latency, no memory traffic.
      mem_ce_seen = 1'b0;
      fetch(32'h0000_0108, d, lat);
      check("hit_rdata", d, 32'hC0DE_0108);
      check("hit_latency", 32'(lat), 32'd2);
      check("hit_mem_ce", {31'b0, mem_ce_seen}, 32'd0);
      check("hit_cnt", 32'(hit_cnt), 32'd1);

      // Backpressure with a second request waiting behind the response.
      start_req(32'h0000_0108);
      wait_resp(lat);
      ce = 1'b1;
      addr = 32'h0000_010C;
      for (int i = 0; i < 5; i++) begin
         check("bp_rdata_valid", {31'b0, rdata_valid}, 32'd1);
         check("bp_rdata", rdata, 32'hC0DE_0108);
         check("bp_req_ready", {31'b0, req_ready}, 32'd0);
         @(negedge clk);
      end
      rdata_ready = 1'b1;
      check("bp_req_ready_release", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      rdata_ready = 1'b0;
      check("bp_next_accept", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      ce = 1'b0;
      wait_resp(lat);
      check("bp_next_latency", 32'(lat), 32'd2);
      check("bp_next_rdata", rdata, 32'hC0DE_010C);
      accept_resp();

      // Set 0 conflict: third line evicts way 0, round robin picks correctly.
      m0 = miss_cnt;
      fetch(32'h0000_0000, d, lat);
      check("cf_a_rdata", d, 32'hC0DE_0000);
      fetch(32'h0000_0800, d, lat);
      check("cf_b_rdata", d, 32'hC0DE_0800);
      fetch(32'h0000_1000, d, lat);
      check("cf_c_rdata", d, 32'hC0DE_1000);
      check("cf_misses", 32'(miss_cnt - m0), 32'd3);
      h0 = hit_cnt;
      fetch(32'h0000_0800, d, lat);
      check("cf_b_rehit", 32'(hit_cnt - h0), 32'd1);
      check("cf_b_rehit_rdata", d, 32'hC0DE_0800);
      m0 = miss_cnt;
      fetch(32'h0000_0000, d, lat);
      check("cf_a_remiss", 32'(miss_cnt - m0), 32'd1);
      check("cf_a_remiss_rdata", d, 32'hC0DE_0000);

      // Invalidate in IDLE blocks a same-cycle request.
      invalidate = 1'b1;
      #1 check("inv_idle_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      invalidate = 1'b0;

      // Invalidate during beat 7: line still delivered, then cleared.
      beat_q.delete();
      m0 = miss_cnt;
      start_req(32'h0000_3040);
      n = 0;
      while (beat_q.size() < 7 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("inv_beat7_reached", 32'(beat_q.size() >= 7), 32'd1);
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      wait_resp(lat);
      check("inv_rdata", rdata, 32'hC0DE_3040);
      accept_resp();
      check("inv_clear_cycle_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("inv_after_req_ready", {31'b0, req_ready}, 32'd1);
      check_line("inv_fill", 32'h0000_3040);
      fetch(32'h0000_3040, d, lat);
      check("inv_refetch_miss", 32'(miss_cnt - m0), 32'd2);
      check("inv_refetch_rdata", d, 32'hC0DE_3040);

      // Reset during beat 3 aborts the refill; the line must refill fully.
      beat_q.delete();
      start_req(32'h0000_4080);
      n = 0;
      while (beat_q.size() < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_beat3_reached", 32'(beat_q.size() >= 3), 32'd1);
      reset = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      beat_q.delete();
      m0 = miss_cnt;
      fetch(32'h0000_4080, d, lat);
      check("rst_refetch_miss", 32'(miss_cnt - m0), 32'd1);
      check("rst_refetch_rdata", d, 32'hC0DE_4080);
      check_line("rst_fill", 32'h0000_4080);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache placed between the fetch stage and the memory bus.
- Generalises the earlier fixed 2-way skeleton: configurable way count, set count and line length.
- Adds per-set round-robin replacement, word-by-word line refill, a hold-until-accepted response handshake, and whole-cache invalidate.
- Storage is flop arrays, so no SRAM macro dependency.

Parameters:
- BUS_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, word width; the CPU and memory buses are the same width.
- LINE_WORDS, 16, words per line, power of two (16 words = 64B).
- WAYS, 2, associativity, power of two, 1..8.
- SETS, 32, sets per way, power of two.
- OFF_W, log2(LINE_WORDS*DATA_WIDTH/8), derived: byte offset bits.
- IDX_W, log2(SETS), derived: index bits.
- TAG_W, BUS_WIDTH-OFF_W-IDX_W, derived: tag bits.

Ports:
- clk  in  1  clock, all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- ce  in  1  fetch request valid.
- addr  in  BUS_WIDTH  byte address, word aligned.
- req_ready  out  1  cache can accept a request this cycle.
- rdata  out  DATA_WIDTH  returned instruction word.
- rdata_valid  out  1  rdata valid; held until accepted.
- rdata_ready  in  1  consumer accepts rdata.
- invalidate  in  1  pulse: clear all valid bits.
- mem_ce  out  1  memory word-read request.
- mem_addr  out  BUS_WIDTH  word address for the refill beat.
- mem_rdata  in  DATA_WIDTH  refill data.
- mem_rdata_valid  in  1  mem_rdata valid for the current mem_addr.
- hit_pulse  out  1  one-cycle pulse per hit (perf counter).
- miss_pulse  out  1  one-cycle pulse per miss (perf counter).

Behaviour:
- Reset values: state=IDLE, all valid bits=0, round-robin pointers=0, read_count=0, req_ready=1, rdata_valid=0, rdata=0, mem_ce=0, mem_addr=0, hit_pulse=0, miss_pulse=0.
- Request acceptance: only when ce && req_ready. req_ready=1 only in IDLE with no pending invalidate. At acceptance, addr is latched into req_addr.

State IDLE:
- On an accepted request, go to LOOKUP.

State LOOKUP (one cycle):
- Compare req_addr tag against all WAYS at req_addr index; a way hits when its valid bit is set and its tag matches.
- Hit: register rdata from the hit way at word offset req_addr[OFF_W-1:2], assert rdata_valid, pulse hit_pulse, go to RESP. Hit latency is 2 cycles from acceptance to rdata_valid.
- Miss: pulse miss_pulse, select victim = lowest-index invalid way, else rr_ptr[index]. Go to REFILL with read_count=0.

State REFILL:
- mem_ce=1, mem_addr = {tag, index, read_count, 2'b00}.
- mem_addr and mem_ce are held stable until mem_rdata_valid.
- On each mem_rdata_valid: write the word into victim line[read_count] and increment read_count. If the word index equals the requested word, also capture it into rdata.
- mem_ce drops for exactly one cycle between beats.
- After beat LINE_WORDS-1: write tag, set valid, advance rr_ptr[index] = (victim+1) mod WAYS, assert rdata_valid, go to RESP.
- The index must not wrap within a line: read_count wraps to 0 only on line completion.

State RESP:
- rdata_valid=1, rdata stable; a new request must not be accepted here.
- On rdata_ready, drop rdata_valid and go to IDLE. The earliest next accept is the cycle after.

Invalidate:
- In IDLE with invalidate=1: clear all valid bits that cycle, and req_ready=0 that cycle (the invalidate wins over a same-cycle ce).
- In LOOKUP/REFILL/RESP: latch a pending flag. The in-flight line still completes and the response is delivered. The clear happens on entering IDLE, and req_ready=0 for that one cycle.
- rr_ptrs are not cleared by invalidate.

Other boundary conditions:
- mem_rdata_valid outside REFILL is ignored.
- Reset asserted mid-refill aborts the refill immediately. All valid bits clear, so the partial line is never visible.
- WAYS=1 degenerates to direct-mapped; rr_ptr is unused and the victim is always way 0.

Decomposition:
- Package icache_pkg holds:
  - the state enum (IDLE, LOOKUP, REFILL, RESP);
  - a helper to split an address into tag, index and offset;
  - the derived-width localparams.
- One sub-module, icache_tag_way: per-way valid/tag array with a registered-index compare. It is instantiated WAYS times and returns a hit bit.
- The data array, FSM and replacement logic stay in the top level.

Test Plan:
- Cold miss at 0x0000_0104 with default parameters:
  - 16 beats are requested at mem_addr 0x100, 0x104, … 0x13C;
  - rdata = word @0x104;
  - miss_pulse=1 once.
- Repeat fetch at 0x0000_0108: hit_pulse, rdata_valid exactly 2 cycles after accept, mem_ce stays 0.
- Set conflict, addresses 0x0000, 0x0800, 0x1000 (same index 0, 2 ways):
  - the third access evicts way 0;
  - refetching 0x0800 then hits;
  - refetching 0x0000 misses.
- Backpressure: rdata_ready held 0 for 5 cycles → rdata_valid and rdata stable, req_ready=0 throughout; the request is accepted the cycle after rdata_ready=1.
- invalidate pulsed mid-refill at beat 7:
  - the refill completes and the data is returned;
  - the next fetch to the same line misses.
- Reset driven low during beat 3 of a refill → outputs return to reset values; the next fetch to that line misses and issues a full 16-beat refill.
